// File: rtl/game_pkg.sv
// Shared game definitions: state and direction codes, the default play time,
// and the button-to-direction encoder used by the controller.
package game_pkg;

  localparam int TIME_LIMIT_DEF = 60;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_LOSE  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    DIR_NONE      = 4'b0000,
    DIR_LEFT      = 4'b0001,
    DIR_UP        = 4'b0010,
    DIR_LEFTUP    = 4'b0011,
    DIR_RIGHT     = 4'b0100,
    DIR_LEFTDOWN  = 4'b0101,
    DIR_RIGHTUP   = 4'b0110,
    DIR_RIGHTDOWN = 4'b0111,
    DIR_DOWN      = 4'b1000
  } dir_t;

  // Opposing pairs and three-or-more presses fall through to NONE.
  function automatic dir_t encode_dir(input logic up, input logic down,
                                      input logic left, input logic right);
    dir_t d;
    case ({up, down, left, right})
      4'b1000: d = DIR_UP;
      4'b0100: d = DIR_DOWN;
      4'b0010: d = DIR_LEFT;
      4'b0001: d = DIR_RIGHT;
      4'b1010: d = DIR_LEFTUP;
      4'b0110: d = DIR_LEFTDOWN;
      4'b1001: d = DIR_RIGHTUP;
      4'b0101: d = DIR_RIGHTDOWN;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for a raw button, with an optional rising-edge pulse
// that stays disarmed until the button has been seen released after reset.
module sync_edge #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1, s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
    end
  end

  assign level = s2;

  generate
    if (EDGE) begin : g_edge
      logic s3, v1, v2, armed;

      // v1/v2 mark when s2 holds a genuine post-reset sample, so a button held
      // through reset cannot arm the detector until it is actually released.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s3    <= 1'b0;
          v1    <= 1'b0;
          v2    <= 1'b0;
          armed <= 1'b0;
        end else begin
          s3    <= s2;
          v1    <= 1'b1;
          v2    <= v1;
          armed <= armed | (v2 & ~s2);
        end
      end

      assign rise = s2 & ~s3 & armed;
    end else begin : g_level
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/game_ctrl.sv
// Game controller: start/play/lose/win FSM, countdown timer and direction
// encoder, driven from synchronized buttons; all outputs are registered.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TIME_LIMIT = TIME_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       tick,
  input  logic       hit,
  input  logic       goal,
  output logic [1:0] state,
  output logic [3:0] mode,
  output logic [7:0] timer
);

  localparam logic [7:0] TIME_INIT = 8'(TIME_LIMIT);

  logic       start_p, start_lvl_unused;
  logic       up_s, down_s, left_s, right_s;
  logic [3:0] dir_rise_unused;

  sync_edge #(.EDGE(1'b1)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .async_in(btn_start),
    .level(start_lvl_unused), .rise(start_p));
  sync_edge #(.EDGE(1'b0)) u_sync_up (
    .clk(clk), .rst_n(rst_n), .async_in(btn_up),
    .level(up_s), .rise(dir_rise_unused[0]));
  sync_edge #(.EDGE(1'b0)) u_sync_down (
    .clk(clk), .rst_n(rst_n), .async_in(btn_down),
    .level(down_s), .rise(dir_rise_unused[1]));
  sync_edge #(.EDGE(1'b0)) u_sync_left (
    .clk(clk), .rst_n(rst_n), .async_in(btn_left),
    .level(left_s), .rise(dir_rise_unused[2]));
  sync_edge #(.EDGE(1'b0)) u_sync_right (
    .clk(clk), .rst_n(rst_n), .async_in(btn_right),
    .level(right_s), .rise(dir_rise_unused[3]));

  state_t     state_q, state_d;
  dir_t       mode_q, mode_d;
  logic [7:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      mode_q  <= DIR_NONE;
      timer_q <= TIME_INIT;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    mode_d  = DIR_NONE;
    case (state_q)
      ST_START: begin
        timer_d = TIME_INIT;
        if (start_p) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // The tick still counts down on the edge where hit or goal ends play.
        if (tick && timer_q != 8'd0) timer_d = timer_q - 8'd1;
        if (hit)                           state_d = ST_LOSE;
        else if (tick && timer_q == 8'd1)  state_d = ST_LOSE;
        else if (goal)                     state_d = ST_WIN;
        else mode_d = encode_dir(up_s, down_s, left_s, right_s);
      end
      ST_LOSE, ST_WIN: begin
        if (start_p) begin
          state_d = ST_START;
          timer_d = TIME_INIT;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  assign state = state_q;
  assign mode  = mode_q;
  assign timer = timer_q;

endmodule
